// File: rtl/bcd2ascii_ser.sv
// Serialises one packed BCD word into an ASCII decimal string on a valid/ready byte stream.
// Supports leading-zero suppression or padding and an optional terminator byte.
module bcd2ascii_ser #(
    parameter int unsigned DIGITS    = 5,
    parameter int unsigned PAD_EN    = 0,
    parameter logic [7:0]  PAD_CHAR  = 8'h20,
    parameter int unsigned TERM_EN   = 1,
    parameter logic [7:0]  TERM_CHAR = 8'h0A
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ce_i,
    input  logic                  start_i,
    input  logic [4*DIGITS-1:0]   dat_bcd_i,
    output logic                  busy_o,
    output logic [7:0]            dat_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o,
    output logic                  err_o
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_TERM = 2'd2
    } state_t;

    state_t          r_state, w_state;
    logic [W-1:0]    r_word,  w_word;
    logic [IW-1:0]   r_idx,   w_idx;
    logic            r_busy,  w_busy;
    logic [7:0]      r_dat,   w_dat;
    logic            r_valid, w_valid;
    logic            r_last,  w_last;
    logic            r_err,   w_err;
    logic            w_accept;

    // Byte for digit position idx: '?' for invalid nibble, pad for leading zeros, else ASCII digit
    function automatic logic [7:0] f_byte(input logic [W-1:0] word, input logic [IW-1:0] idx);
        logic [3:0] nib;
        logic       upper_zero;
        nib        = word[{idx, 2'b00} +: 4];
        upper_zero = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (IW'(i) >= idx && word[4*i +: 4] != 4'd0) upper_zero = 1'b0;
        end
        if (nib > 4'd9)                                  return 8'h3F;
        else if (PAD_EN != 0 && idx != '0 && upper_zero) return PAD_CHAR;
        else                                             return {4'h3, nib};
    endfunction

    // Index of the highest non-zero nibble; zero word maps to index 0
    function automatic logic [IW-1:0] f_msd(input logic [W-1:0] word);
        logic [IW-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (word[4*i +: 4] != 4'd0) idx = IW'(i);
        end
        return idx;
    endfunction

    function automatic logic f_err(input logic [W-1:0] word);
        logic e;
        e = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (word[4*i +: 4] > 4'd9) e = 1'b1;
        end
        return e;
    endfunction

    // Next-state and registered-output computation
    always_comb begin
        w_state  = r_state;
        w_word   = r_word;
        w_idx    = r_idx;
        w_busy   = r_busy;
        w_dat    = r_dat;
        w_valid  = r_valid;
        w_last   = r_last;
        w_err    = r_err;
        w_accept = r_valid & ready_i;

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_word  = dat_bcd_i;
                    w_idx   = (PAD_EN != 0) ? IW'(DIGITS - 1) : f_msd(dat_bcd_i);
                    w_busy  = 1'b1;
                    w_err   = f_err(dat_bcd_i);
                    w_dat   = f_byte(dat_bcd_i, w_idx);
                    w_valid = 1'b1;
                    w_last  = (w_idx == '0) && (TERM_EN == 0);
                    w_state = S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_accept) begin
                    if (r_idx == '0) begin
                        if (TERM_EN != 0) begin
                            w_dat   = TERM_CHAR;
                            w_last  = 1'b1;
                            w_state = S_TERM;
                        end else begin
                            w_valid = 1'b0;
                            w_last  = 1'b0;
                            w_busy  = 1'b0;
                            w_state = S_IDLE;
                        end
                    end else begin
                        w_idx  = r_idx - IW'(1);
                        w_dat  = f_byte(r_word, w_idx);
                        w_last = (w_idx == '0) && (TERM_EN == 0);
                    end
                end
            end
            S_TERM: begin
                if (w_accept) begin
                    w_valid = 1'b0;
                    w_last  = 1'b0;
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                end
            end
            default: begin
                w_valid = 1'b0;
                w_last  = 1'b0;
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
        endcase
    end

    // State register; clock enable freezes everything
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_word  <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_dat   <= 8'h00;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else if (ce_i) begin
            r_state <= w_state;
            r_word  <= w_word;
            r_idx   <= w_idx;
            r_busy  <= w_busy;
            r_dat   <= w_dat;
            r_valid <= w_valid;
            r_last  <= w_last;
            r_err   <= w_err;
        end
    end

    assign busy_o  = r_busy;
    assign dat_o   = r_dat;
    assign valid_o = r_valid;
    assign last_o  = r_last;
    assign err_o   = r_err;

endmodule

// File: tb/tb_bcd2ascii_ser.sv
// Bench for bcd2ascii_ser: directed and randomized frames on a default instance and a
// padded/no-terminator instance, checked against a string/digit-level reference model.
module tb_bcd2ascii_ser;

    localparam int unsigned DIGITS = 5;

    typedef logic [7:0] bq_t[$];

    logic        clk, rst_n, ce, start, ready, sel;
    logic [19:0] dat_bcd;
    logic        start_a, start_b;
    logic        busy_a, valid_a, last_a, err_a;
    logic        busy_b, valid_b, last_b, err_b;
    logic [7:0]  dat_a, dat_b;
    logic        w_busy, w_valid, w_last, w_err;
    logic [7:0]  w_dat;

    int n_vec = 0;
    int n_err = 0;

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign w_busy  = sel ? busy_b  : busy_a;
    assign w_valid = sel ? valid_b : valid_a;
    assign w_last  = sel ? last_b  : last_a;
    assign w_err   = sel ? err_b   : err_a;
    assign w_dat   = sel ? dat_b   : dat_a;

    bcd2ascii_ser dut_a (
        .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .start_i(start_a), .dat_bcd_i(dat_bcd),
        .busy_o(busy_a), .dat_o(dat_a), .valid_o(valid_a), .ready_i(ready),
        .last_o(last_a), .err_o(err_a)
    );

    bcd2ascii_ser #(.PAD_EN(1), .TERM_EN(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .start_i(start_b), .dat_bcd_i(dat_bcd),
        .busy_o(busy_b), .dat_o(dat_b), .valid_o(valid_b), .ready_i(ready),
        .last_o(last_b), .err_o(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
        return q;
    endfunction

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] w;
        int          t;
        w = '0;
        t = v;
        for (int i = 0; i < 5; i++) begin
            w[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return w;
    endfunction

    // Digit-level model: suppress or pad zeros above the most significant non-zero digit
    function automatic bq_t model(input logic [19:0] w, input bit pad, input bit term);
        bq_t q;
        int  msd;
        int  d;
        msd = 0;
        for (int i = 0; i < 5; i++) if (w[4*i +: 4] != 4'd0) msd = i;
        for (int i = 4; i >= 0; i--) begin
            d = int'(w[4*i +: 4]);
            if (i > msd) begin
                if (pad) q.push_back(8'h20);
            end else begin
                q.push_back((d > 9) ? 8'h3F : 8'(8'h30 + d));
            end
        end
        if (term) q.push_back(8'h0A);
        return q;
    endfunction

    function automatic logic has_bad(input logic [19:0] w);
        logic b;
        b = 1'b0;
        for (int i = 0; i < 5; i++) if (w[4*i +: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    // rmode: 0 ready held high, 1 ready toggling, 2 random ready and clock enable
    task automatic run_frame(input bit s, input logic [19:0] w, input int rmode,
                             input bit poke, input bq_t exp, input string tag);
        bq_t        got;
        bit         stall;
        bit         acc;
        logic [7:0] pd;
        logic       pl;
        logic       experr;
        int         cyc;
        experr = has_bad(w);
        sel    = s;
        cyc    = 0;
        while (w_busy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_idle"}, 32'(w_busy), 32'(0));
        dat_bcd = w;
        start   = 1'b1;
        ce      = 1'b1;
        ready   = (rmode == 0);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_first_valid"}, 32'(w_valid), 32'(1));
        chk({tag, "_busy"}, 32'(w_busy), 32'(1));
        chk({tag, "_err"}, 32'(w_err), 32'(experr));
        stall = 1'b0;
        pd    = '0;
        pl    = 1'b0;
        cyc   = 0;
        while (got.size() < exp.size() && cyc < 400) begin
            if (!w_valid) chk({tag, "_last_wo_valid"}, 32'(w_last), 32'(0));
            if (stall) begin
                chk({tag, "_hold_valid"}, 32'(w_valid), 32'(1));
                chk({tag, "_hold_dat"}, 32'(w_dat), 32'(pd));
                chk({tag, "_hold_last"}, 32'(w_last), 32'(pl));
            end
            if (rmode == 0) chk({tag, "_sustain"}, 32'(w_valid), 32'(1));
            case (rmode)
                0:       begin ready = 1'b1; ce = 1'b1; end
                1:       begin ready = ~ready; ce = 1'b1; end
                default: begin
                    ready = 1'($urandom_range(0, 1));
                    ce    = ($urandom_range(0, 3) != 0);
                end
            endcase
            if (poke && cyc == 1) begin
                start   = 1'b1;
                dat_bcd = ~w;
            end else begin
                start = 1'b0;
            end
            acc = w_valid && ready && ce;
            if (acc) begin
                chk($sformatf("%s_byte%0d", tag, got.size()), 32'(w_dat), 32'(exp[got.size()]));
                chk($sformatf("%s_last%0d", tag, got.size()), 32'(w_last),
                    32'(got.size() == exp.size() - 1));
                got.push_back(w_dat);
            end
            stall = w_valid && !acc;
            pd    = w_dat;
            pl    = w_last;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        ready = 1'b0;
        ce    = 1'b1;
        chk({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
        chk({tag, "_done_busy"}, 32'(w_busy), 32'(0));
        chk({tag, "_done_valid"}, 32'(w_valid), 32'(0));
        chk({tag, "_err_held"}, 32'(w_err), 32'(experr));
    endtask

    initial begin
        logic [19:0] w;
        int          v;
        rst_n   = 1'b0;
        ce      = 1'b0;
        start   = 1'b0;
        ready   = 1'b0;
        sel     = 1'b0;
        dat_bcd = '0;
        @(negedge clk);
        chk("rst_busy", 32'(busy_a), 32'(0));
        chk("rst_valid", 32'(valid_a), 32'(0));
        chk("rst_last", 32'(last_a), 32'(0));
        chk("rst_err", 32'(err_a), 32'(0));
        chk("rst_dat", 32'(dat_a), 32'(0));
        chk("rst_valid_b", 32'(valid_b), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        ce    = 1'b1;
        @(negedge clk);

        run_frame(0, 20'h00042, 0, 0, str2q("42\n"), "t1_42");
        run_frame(0, 20'h00000, 0, 0, str2q("0\n"), "t2_zero");
        run_frame(0, 20'h10010, 0, 0, str2q("10010\n"), "t2_10010");
        run_frame(0, 20'h09999, 1, 0, str2q("9999\n"), "t3_toggle");
        run_frame(1, 20'h00007, 0, 0, str2q("    7"), "t4_pad7");
        run_frame(1, 20'h00000, 1, 0, str2q("    0"), "t4_pad0");
        run_frame(0, 20'h000A5, 0, 0, model(20'h000A5, 0, 1), "t5_bad");
        run_frame(0, 20'h00042, 0, 0, str2q("42\n"), "t5_clear");
        run_frame(0, 20'h31415, 1, 1, str2q("31415\n"), "t6_poke");
        run_frame(0, 20'h27182, 2, 1, str2q("27182\n"), "t6_ce");

        // Asynchronous reset in the middle of a stalled frame
        sel     = 1'b0;
        dat_bcd = 20'h12345;
        start   = 1'b1;
        ce      = 1'b1;
        ready   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t6_pre_rst_valid", 32'(valid_a), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(valid_a), 32'(0));
        chk("t6_rst_busy", 32'(busy_a), 32'(0));
        chk("t6_rst_last", 32'(last_a), 32'(0));
        chk("t6_rst_dat", 32'(dat_a), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(0, 20'h00042, 0, 0, str2q("42\n"), "t6_after_rst");

        // Sweep of decimal values through the default instance
        for (int k = 0; k <= 10010; k += 7) begin
            run_frame(0, to_bcd(k), (k % 3 == 0) ? 2 : 0, 0,
                      str2q($sformatf("%0d\n", k)), $sformatf("sweep_%0d", k));
        end

        // Random valid values on the padded instance
        for (int k = 0; k < 60; k++) begin
            v = int'($urandom_range(0, 99999));
            run_frame(1, to_bcd(v), int'($urandom_range(0, 2)), 0,
                      str2q($sformatf("%5d", v)), $sformatf("padrnd_%0d", v));
        end

        // Random raw words including invalid nibbles on both instances
        for (int k = 0; k < 80; k++) begin
            w = 20'($urandom);
            if (k[0]) run_frame(1, w, 2, 0, model(w, 1, 0), $sformatf("rawb_%05h", w));
            else      run_frame(0, w, 2, 0, model(w, 0, 1), $sformatf("rawa_%05h", w));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
